// File: rtl/cpu_imm_pkg.sv
// Shared immediate-extender encodings: extender modes, merge ops, word classes and beat payload.
package cpu_imm_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned IMM_W  = 8;
  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_SIGN       = 2'b00,
    MODE_ZERO       = 2'b01,
    MODE_ALIGN_HIGH = 2'b10
  } imm_mode_e;

  typedef enum logic {
    OP_LOAD = 1'b0,
    OP_OR   = 1'b1
  } imm_op_e;

  typedef enum logic [1:0] {
    KIND_SIGN  = 2'b00,
    KIND_ZERO  = 2'b01,
    KIND_HIGH  = 2'b10,
    KIND_SPLIT = 2'b11
  } imm_kind_e;

  typedef struct packed {
    imm_mode_e        mode;
    logic [IMM_W-1:0] imm;
    imm_op_e          op;
    logic             last;
  } imm_beat_t;

  localparam imm_beat_t BEAT_IDLE = '{mode: MODE_SIGN, imm: '0, op: OP_LOAD, last: 1'b0};

  // Extender mode used for a word's first (or only) beat.
  function automatic imm_mode_e kind_to_mode(input imm_kind_e kind);
    imm_mode_e mode;
    mode = MODE_SIGN;
    case (kind)
      KIND_SIGN:  mode = MODE_SIGN;
      KIND_ZERO:  mode = MODE_ZERO;
      KIND_HIGH:  mode = MODE_ALIGN_HIGH;
      KIND_SPLIT: mode = MODE_ALIGN_HIGH;
      default:    mode = MODE_SIGN;
    endcase
    return mode;
  endfunction

endpackage

// File: rtl/imm_classify.sv
// Combinational classifier: picks the cheapest extender form for a 16-bit constant.
module imm_classify
  import cpu_imm_pkg::*;
(
  input  logic [DATA_W-1:0] value_i,
  output imm_kind_e         kind_o_c,
  output logic [IMM_W-1:0]  byte_o_c
);

  logic [IMM_W-1:0] hi_c;
  logic [IMM_W-1:0] lo_c;

  assign hi_c = value_i[DATA_W-1 -: IMM_W];
  assign lo_c = value_i[IMM_W-1:0];

  // First match wins; SPLIT reports the high byte since that is its first beat.
  always_comb begin
    kind_o_c = KIND_SPLIT;
    byte_o_c = hi_c;
    if (hi_c == {IMM_W{lo_c[IMM_W-1]}}) begin
      kind_o_c = KIND_SIGN;
      byte_o_c = lo_c;
    end else if (hi_c == '0) begin
      kind_o_c = KIND_ZERO;
      byte_o_c = lo_c;
    end else if (lo_c == '0) begin
      kind_o_c = KIND_HIGH;
      byte_o_c = hi_c;
    end
  end

endmodule

// File: rtl/imm_splitter.sv
// Encodes 16-bit constants as one or two 8-bit extender beats and counts two-beat words.
module imm_splitter
  import cpu_imm_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  input  logic [DATA_W-1:0]    in_value,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [MODE_W-1:0]    out_mode,
  output logic [IMM_W-1:0]     out_imm,
  output logic                 out_op,
  output logic                 out_last,
  input  logic                 cnt_clear,
  output logic [CNT_WIDTH-1:0] split_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ONE  = 2'b01,
    HI   = 2'b10,
    LO   = 2'b11
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_e               state_q, state_d;
  imm_beat_t            beat_q, beat_d;
  logic [IMM_W-1:0]     lo_q, lo_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  imm_kind_e            kind_c;
  logic [IMM_W-1:0]     cls_byte_c;
  logic                 accept_c;
  logic                 out_fire_c;

  imm_classify u_classify (
    .value_i  (in_value),
    .kind_o_c (kind_c),
    .byte_o_c (cls_byte_c)
  );

  assign accept_c   = in_valid && in_ready_q;
  assign out_fire_c = out_valid_q && out_ready;

  // Next-state, next-beat and counter logic.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (accept_c) begin
          lo_d = in_value[IMM_W-1:0];
          if (kind_c == KIND_SPLIT) begin
            state_d = HI;
            beat_d  = '{mode: MODE_ALIGN_HIGH, imm: cls_byte_c, op: OP_LOAD, last: 1'b0};
          end else begin
            state_d = ONE;
            beat_d  = '{mode: kind_to_mode(kind_c), imm: cls_byte_c, op: OP_LOAD, last: 1'b1};
          end
        end
      end
      HI: begin
        if (out_fire_c) begin
          state_d = LO;
          beat_d  = '{mode: MODE_ZERO, imm: lo_q, op: OP_OR, last: 1'b1};
        end
      end
      ONE, LO: begin
        if (out_fire_c) begin
          state_d = IDLE;
          beat_d  = BEAT_IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        beat_d  = BEAT_IDLE;
      end
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d != IDLE);

    // Clear wins over a same-cycle increment.
    if (cnt_clear) begin
      cnt_d = '0;
    end else if (accept_c && (kind_c == KIND_SPLIT) && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      beat_q      <= BEAT_IDLE;
      lo_q        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      lo_q        <= lo_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_mode  = beat_q.mode;
  assign out_imm   = beat_q.imm;
  assign out_op    = beat_q.op;
  assign out_last  = beat_q.last;
  assign split_cnt = cnt_q;

endmodule

// File: doc/imm_splitter.md
IMM_SPLITTER -- requirements
Module: imm_splitter

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 8, width of the split-event counter.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  in_value holds a word to encode.
REQ-005 SHALL have port in_value  input  16  constant to express as 8-bit immediates.
REQ-006 SHALL have port in_ready  output  1  block accepts a word this cycle.
REQ-007 SHALL have port out_valid  output  1  out_mode/out_imm/out_op/out_last are valid.
REQ-008 SHALL have port out_ready  input  1  consumer accepts the current beat.
REQ-009 SHALL have port out_mode  output  2  extender mode: 00 sign, 01 zero, 10 align-high.
REQ-010 SHALL have port out_imm  output  8  immediate byte for that mode.
REQ-011 SHALL have port out_op  output  1  0 = load the result, 1 = OR-merge into the prior result.
REQ-012 SHALL have port out_last  output  1  final beat of the current word.
REQ-013 SHALL have port cnt_clear  input  1  synchronous clear of split_cnt.
REQ-014 SHALL have port split_cnt  output  CNT_WIDTH  number of words that needed two beats.

Function
REQ-015 SHALL classify each word with first-match priority.
- SIGN, one beat, mode 00, imm = v[7:0]: v[15:8] all equal to v[7].
- ZERO, one beat, mode 01, imm = v[7:0]: v[15:8] = 0.
- HIGH, one beat, mode 10, imm = v[15:8]: v[7:0] = 0.
- otherwise SPLIT, two beats.
REQ-016 SHALL emit SPLIT as two beats, in this order.
- Beat 1: mode 10, imm = v[15:8], op 0, last 0.
- Beat 2: mode 01, imm = v[7:0], op 1, last 1.
REQ-017 SHALL drive op 0 and last 1 on every one-beat word.
REQ-018 SHALL implement FSM states IDLE, ONE, HI, LO.
- IDLE -> ONE or HI on accept.
- ONE -> IDLE on out handshake.
- HI -> LO on out handshake.
- LO -> IDLE on out handshake.
REQ-019 SHALL assert in_ready only in IDLE; accept = in_valid && in_ready.
REQ-020 SHALL assert out_valid exactly in ONE, HI and LO, one cycle after accept, with all output fields registered.
REQ-021 SHALL hold all out_* fields stable while out_valid && !out_ready.
REQ-022 SHALL NOT change in_value capture after accept; later in_value changes have no effect.
REQ-023 SHALL increment split_cnt by 1 on each SPLIT accept, saturating at 2^CNT_WIDTH-1.
REQ-024 SHALL give cnt_clear priority over a same-cycle increment; the result is 0.
REQ-025 SHALL ignore in_valid outside IDLE and never drop a word that has been accepted.

Reset
REQ-026 SHALL, on reset_n low, immediately drive state IDLE, in_ready 1, out_valid 0, out_mode 00, out_imm 0, out_op 0, out_last 0 and split_cnt 0.
REQ-027 SHALL discard any word in flight when reset asserts mid-word, including between the two SPLIT beats; no beat follows deassertion.
REQ-028 SHALL accept a new word on the first clock edge after reset_n rises.

Structure
REQ-029 SHALL take the mode encodings SIGN/ZERO/ALIGN_HIGH and the op encodings from shared package cpu_imm_pkg; the CPU immediate extender uses the same package.
REQ-030 SHALL place classification in one combinational sub-module imm_classify: 16-bit in; kind and byte out.

Verification
REQ-031 SHALL cover: accept 0xFF85 -> one beat mode 00, imm 0x85, op 0, last 1; split_cnt unchanged.
REQ-032 SHALL cover: accept 0x00C3 -> one beat mode 01, imm 0xC3; accept 0x5A00 -> one beat mode 10, imm 0x5A.
REQ-033 SHALL cover: accept 0x1234 with out_ready held low 3 cycles -> beat (10, 0x12, op 0, last 0) stable, then (01, 0x34, op 1, last 1); split_cnt +1.
REQ-034 SHALL cover: 0x0000 -> mode 00, imm 0x00; 0x8000 -> mode 10, imm 0x80; 0x007F -> mode 00; 0x0080 -> mode 01.
REQ-035 SHALL cover: 256 SPLIT words -> split_cnt saturates at 255; cnt_clear asserted with a SPLIT accept -> 0.
REQ-036 SHALL cover: reset_n pulsed low while in LO -> out_valid 0 asynchronously, no LO beat after release, next word 0xABCD encodes correctly.
